// File: rtl/nonoverlap_clkgen_param.sv
// ============================================================================
// nonoverlap_clkgen_param
// Programmable non-overlapping clock pair plus phase-shifted auxiliary clocks.
// Revision: 1.0
// ============================================================================
`default_nettype none

module nonoverlap_clkgen_param #(
  parameter int N_CH       = 2,
  parameter int CNT_W      = 8,
  parameter int RST_PERIOD = 31,
  parameter int RST_DEAD   = 2
) (
  input  logic                    clk_in,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [CNT_W-1:0]        cfg_period,
  input  logic [CNT_W-1:0]        cfg_dead,
  input  logic [N_CH*CNT_W-1:0]   cfg_phase,
  output logic                    clk_out_mod,
  output logic                    clk_out_modn,
  output logic [N_CH-1:0]         clk_out_aux,
  output logic                    sync_out,
  output logic                    cfg_err
);

  localparam int W1 = CNT_W + 1;
  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_RUN      = 2'd1;
  localparam logic [1:0] S_STOPPING = 2'd2;

  logic [1:0]            r_state, w_next_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      r_act_p, r_act_d, r_sh_p, r_sh_d;
  logic [N_CH*CNT_W-1:0] r_act_ph, r_sh_ph;
  logic                  r_sh_pend;

  logic                  w_running, w_at_end, w_apply, w_xfer, w_cfg_ok;
  logic [W1-1:0]         w_half_cfg, w_half, w_cnt1, w_p1, w_d1;
  logic                  w_mod, w_modn, w_sync;
  logic [N_CH-1:0]       w_aux;

  // A pending shadow applies at the period boundary; that same cycle frees the slot.
  assign w_running = (r_state != S_IDLE);
  assign w_at_end  = w_running && (r_cnt == r_act_p);
  assign w_apply   = r_sh_pend && (w_at_end || (r_state == S_IDLE));
  assign cfg_ready = !r_sh_pend || w_apply;
  assign w_xfer    = cfg_valid && cfg_ready;

  assign w_half_cfg = ({1'b0, cfg_period} + W1'(1)) >> 1;

  always_comb begin
    w_cfg_ok = (cfg_period != '0) && ({1'b0, cfg_dead} < w_half_cfg);
    for (int i = 0; i < N_CH; i++) begin
      if (cfg_phase[i*CNT_W +: CNT_W] > cfg_period) w_cfg_ok = 1'b0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:     if (enable) w_next_state = S_RUN;
      S_RUN:      if (!enable) w_next_state = S_STOPPING;
      S_STOPPING: begin
        if (enable)        w_next_state = S_RUN;
        else if (w_at_end) w_next_state = S_IDLE;
      end
      default:    w_next_state = S_IDLE;
    endcase
  end

  assign w_cnt1 = {1'b0, r_cnt};
  assign w_p1   = {1'b0, r_act_p};
  assign w_d1   = {1'b0, r_act_d};
  assign w_half = (w_p1 + W1'(1)) >> 1;

  always_comb begin
    w_mod  = (w_cnt1 >= w_d1) && (w_cnt1 < w_half);
    w_modn = (w_cnt1 >= (w_half + w_d1)) && (w_cnt1 <= w_p1);
    w_sync = (r_cnt == '0);
  end

  // Distance from the channel's phase, wrapped into 0..P.
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_aux
    logic [W1-1:0] w_ph, w_diff;
    assign w_ph   = {1'b0, r_act_ph[gi*CNT_W +: CNT_W]};
    assign w_diff = (w_cnt1 >= w_ph) ? (w_cnt1 - w_ph)
                                     : (w_cnt1 + w_p1 + W1'(1) - w_ph);
    assign w_aux[gi] = (w_diff < w_half);
  end

  always_ff @(posedge clk_in) begin
    if (reset || !w_running || w_at_end) r_cnt <= '0;
    else                                 r_cnt <= r_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_act_p   <= CNT_W'(RST_PERIOD);
      r_act_d   <= CNT_W'(RST_DEAD);
      r_act_ph  <= '0;
      r_sh_p    <= '0;
      r_sh_d    <= '0;
      r_sh_ph   <= '0;
      r_sh_pend <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      cfg_err <= w_xfer && !w_cfg_ok;
      if (w_apply) begin
        r_act_p  <= r_sh_p;
        r_act_d  <= r_sh_d;
        r_act_ph <= r_sh_ph;
      end
      if (w_xfer && w_cfg_ok) begin
        r_sh_p    <= cfg_period;
        r_sh_d    <= cfg_dead;
        r_sh_ph   <= cfg_phase;
        r_sh_pend <= 1'b1;
      end else if (w_apply) begin
        r_sh_pend <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset || !w_running) begin
      clk_out_mod  <= 1'b0;
      clk_out_modn <= 1'b0;
      clk_out_aux  <= '0;
      sync_out     <= 1'b0;
    end else begin
      clk_out_mod  <= w_mod;
      clk_out_modn <= w_modn;
      clk_out_aux  <= w_aux;
      sync_out     <= w_sync;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_nonoverlap_clkgen_param.sv
// ============================================================================
// tb_nonoverlap_clkgen_param
// Scoreboard bench: driver pushes expected outputs, monitor pops and compares.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_nonoverlap_clkgen_param;

  logic        clk = 1'b0;
  logic        reset, enable, cfg_valid, cfg_ready;
  logic [7:0]  cfg_period, cfg_dead;
  logic [15:0] cfg_phase;
  logic        mod_o, modn_o, sync_o, err_o;
  logic [1:0]  aux_o;

  always #5 clk = ~clk;

  nonoverlap_clkgen_param #(.N_CH(2), .CNT_W(8), .RST_PERIOD(31), .RST_DEAD(2)) dut (
    .clk_in(clk), .reset(reset), .enable(enable), .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready), .cfg_period(cfg_period), .cfg_dead(cfg_dead),
    .cfg_phase(cfg_phase), .clk_out_mod(mod_o), .clk_out_modn(modn_o),
    .clk_out_aux(aux_o), .sync_out(sync_o), .cfg_err(err_o)
  );

  int checks = 0;
  int errors = 0;
  int n_sync = 0;
  int n_err  = 0;
  int cyc    = 0;
  logic [6:0] exp_q[$];

  // Reference model state (0 idle, 1 run, 2 stopping)
  int m_st, m_cnt, m_p, m_d, m_pend, s_p, s_d;
  int m_ph[2];
  int s_ph[2];
  bit g_xfer;

  task automatic step(input bit rst, input bit en, input bit cv,
                      input int cp, input int cd, input int ph0, input int ph1);
    int  h, nst, ncnt;
    bit  run, end_c, apply, rdy, ok;
    logic [6:0] e;
    @(negedge clk);
    reset = rst; enable = en; cfg_valid = cv;
    cfg_period = 8'(cp); cfg_dead = 8'(cd); cfg_phase = {8'(ph1), 8'(ph0)};
    g_xfer = 1'b0;
    e = '0;
    if (rst) begin
      m_st = 0; m_cnt = 0; m_p = 31; m_d = 2; m_ph[0] = 0; m_ph[1] = 0;
      m_pend = 0; s_p = 0; s_d = 0; s_ph[0] = 0; s_ph[1] = 0;
    end else begin
      run = (m_st != 0);
      h = (m_p + 1) / 2;
      e[6] = run && m_cnt >= m_d && m_cnt < h;
      e[5] = run && m_cnt >= h + m_d && m_cnt <= m_p;
      for (int i = 0; i < 2; i++)
        e[3+i] = run && (((m_cnt - m_ph[i] + m_p + 1) % (m_p + 1)) < h);
      e[2] = run && m_cnt == 0;
      end_c = run && m_cnt == m_p;
      apply = (m_pend != 0) && (end_c || m_st == 0);
      rdy = (m_pend == 0) || apply;
      g_xfer = cv && rdy;
      ok = cp >= 1 && cd < (cp + 1) / 2 && ph0 <= cp && ph1 <= cp;
      e[1] = g_xfer && !ok;
      case (m_st)
        0: nst = en ? 1 : 0;
        1: nst = en ? 1 : 2;
        default: nst = en ? 1 : (end_c ? 0 : 2);
      endcase
      ncnt = (run && !end_c) ? m_cnt + 1 : 0;
      if (apply) begin
        m_p = s_p; m_d = s_d; m_ph[0] = s_ph[0]; m_ph[1] = s_ph[1];
      end
      if (g_xfer && ok) begin
        s_p = cp; s_d = cd; s_ph[0] = ph0; s_ph[1] = ph1; m_pend = 1;
      end else if (apply) begin
        m_pend = 0;
      end
      m_st = nst; m_cnt = ncnt;
    end
    e[0] = (m_pend == 0) || ((m_st != 0 && m_cnt == m_p) || m_st == 0);
    exp_q.push_back(e);
  endtask

  task automatic run_n(input bit en, input int n);
    for (int i = 0; i < n; i++) step(1'b0, en, 1'b0, 0, 0, 0, 0);
  endtask

  task automatic offer(input bit en, input int cp, input int cd, input int ph0, input int ph1);
    int k;
    k = 0;
    do begin
      step(1'b0, en, 1'b1, cp, cd, ph0, ph1);
      k++;
    end while (!g_xfer && k < 200);
    if (!g_xfer) begin
      checks++; errors++;
      $display("FAIL offer_timeout got no handshake want handshake within 200 cycles");
    end
  endtask

  task automatic wait_cnt(input bit en, input int target);
    int k;
    k = 0;
    while (m_cnt != target && k < 200) begin
      step(1'b0, en, 1'b0, 0, 0, 0, 0);
      k++;
    end
    if (m_cnt != target) begin
      checks++; errors++;
      $display("FAIL wait_cnt got cnt %0d want %0d", m_cnt, target);
    end
  endtask

  task automatic settle();
    @(posedge clk); #2;
  endtask

  always @(posedge clk) begin
    logic [6:0] e, a;
    #1;
    cyc++;
    if (sync_o) n_sync++;
    if (err_o)  n_err++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {mod_o, modn_o, aux_o, sync_o, err_o, cfg_ready};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL outputs cycle %0d got mod/modn/aux/sync/err/rdy=%b want %b", cyc, a, e);
      end
      checks++;
      if (mod_o && modn_o) begin
        errors++;
        $display("FAIL overlap cycle %0d got mod=1 modn=1 want not both", cyc);
      end
    end
  end

  initial begin
    int s0, e0;
    reset = 1'b1; enable = 1'b0; cfg_valid = 1'b0;
    cfg_period = '0; cfg_dead = '0; cfg_phase = '0;

    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
    run_n(1'b0, 2);
    settle();

    // Default waveform: 70 cycles gives period starts at cycles 2, 34, 66
    s0 = n_sync;
    run_n(1'b1, 70);
    settle();
    checks++;
    if (n_sync - s0 != 3) begin
      errors++;
      $display("FAIL sync_count got %0d want 3", n_sync - s0);
    end

    // D=16 with P=31 is invalid: exactly one error pulse
    e0 = n_err;
    offer(1'b1, 31, 16, 0, 0);
    run_n(1'b1, 10);
    settle();
    checks++;
    if (n_err - e0 != 1) begin
      errors++;
      $display("FAIL cfg_err_count got %0d want 1", n_err - e0);
    end

    // Back-to-back offers mid-period; second waits for the boundary
    offer(1'b1, 9, 1, 0, 5);
    offer(1'b1, 9, 2, 3, 0);
    run_n(1'b1, 30);

    // Restore default timing, then stop at cnt=10
    offer(1'b1, 31, 2, 0, 0);
    run_n(1'b1, 20);
    wait_cnt(1'b1, 10);
    run_n(1'b0, 30);
    settle();
    checks++;
    if (m_st != 0) begin
      errors++;
      $display("FAIL stop_to_idle got state %0d want 0", m_st);
    end
    run_n(1'b0, 3);
    run_n(1'b1, 40);

    // Reset mid-period with a pending shadow
    wait_cnt(1'b1, 3);
    offer(1'b1, 15, 3, 4, 8);
    wait_cnt(1'b1, 7);
    step(1'b1, 1'b1, 1'b0, 0, 0, 0, 0);
    run_n(1'b0, 3);
    run_n(1'b1, 40);
    settle();
    checks++;
    if (m_p != 31 || m_d != 2) begin
      errors++;
      $display("FAIL pending_lost got P=%0d D=%0d want P=31 D=2", m_p, m_d);
    end
    settle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
